// File: rtl/ov_fifo_write.sv
// ov_fifo_write: write-side controller for an AL422 frame FIFO fed by an OV-series camera.
// Synchronises the camera VSYNC/HREF strobes, pulses the FIFO write-pointer reset at the start
// of each frame, enables writes for the active part of the frame, and hands complete frames
// (exactly EXPECT_LINES lines) over to the reader.
//
// Ports
//   clk_25MHz    sole clock, all state on its rising edge
//   rst_n        asynchronous active-low reset
//   initialized  camera register setup complete
//   vsync, href  raw camera strobes (asynchronous)
//   frame_read   reader status: low while draining the FIFO, high when idle
//   wen          AL422 write enable (active-high)
//   wrst         AL422 write-pointer reset (active-low)
//   new_frame    a complete, unclaimed frame is in the FIFO
//   frame_count  number of frames handed off (wraps at 256)
//   frame_err    one-cycle pulse when a captured frame has the wrong line count
module ov_fifo_write #(
  parameter int unsigned EXPECT_LINES = 240,
  parameter int unsigned WRST_CYCLES  = 4
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       initialized,
  input  logic       vsync,
  input  logic       href,
  input  logic       frame_read,
  output logic       wen,
  output logic       wrst,
  output logic       new_frame,
  output logic [7:0] frame_count,
  output logic       frame_err
);

  localparam int unsigned CntW = (WRST_CYCLES < 2) ? 1 : $clog2(WRST_CYCLES + 1);
  localparam logic [CntW-1:0] WrstLoad = CntW'(WRST_CYCLES);
  localparam logic [8:0]      ExpLines = 9'(EXPECT_LINES);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StWrst,
    StWaitFall,
    StCapture,
    StHandoff,
    StBusy
  } state_e;

  state_e          state_q;
  logic [2:0]      vs_sync_q;   // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0]      hr_sync_q;
  logic [CntW-1:0] wrst_cnt_q;
  logic [8:0]      line_cnt_q;
  logic            fall_pend_q; // vsync fall seen while wrst was still being held low

  logic       vs_rise, vs_fall, hr_rise;
  logic [8:0] line_cnt_inc;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync_q <= '0;
      hr_sync_q <= '0;
    end else begin
      vs_sync_q <= {vs_sync_q[1:0], vsync};
      hr_sync_q <= {hr_sync_q[1:0], href};
    end
  end

  always_comb begin
    vs_rise = vs_sync_q[1] & ~vs_sync_q[2];
    vs_fall = ~vs_sync_q[1] & vs_sync_q[2];
    hr_rise = hr_sync_q[1] & ~hr_sync_q[2];
    // A line arriving together with the closing vsync still counts toward the compare.
    line_cnt_inc = line_cnt_q;
    if (hr_rise && (line_cnt_q != 9'h1FF)) begin
      line_cnt_inc = line_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wen         <= 1'b0;
      wrst        <= 1'b1;
      new_frame   <= 1'b0;
      frame_count <= 8'd0;
      frame_err   <= 1'b0;
      line_cnt_q  <= 9'd0;
      wrst_cnt_q  <= '0;
      fall_pend_q <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if ((state_q != StIdle) && !initialized) begin
        // Camera lost its setup: abandon whatever frame is in flight, keep the count.
        state_q     <= StIdle;
        wen         <= 1'b0;
        wrst        <= 1'b1;
        new_frame   <= 1'b0;
        fall_pend_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (initialized && frame_read && !new_frame) begin
              state_q <= StWaitStart;
            end
          end
          StWaitStart: begin
            if (vs_rise) begin
              wrst        <= 1'b0;
              wrst_cnt_q  <= WrstLoad;
              fall_pend_q <= 1'b0;
              state_q     <= StWrst;
            end
          end
          StWrst: begin
            if (vs_fall) begin
              fall_pend_q <= 1'b1;
            end
            if (wrst_cnt_q <= CntW'(1)) begin
              wrst        <= 1'b1;
              fall_pend_q <= 1'b0;
              if (fall_pend_q || vs_fall) begin
                wen        <= 1'b1;
                line_cnt_q <= 9'd0;
                state_q    <= StCapture;
              end else begin
                state_q <= StWaitFall;
              end
            end else begin
              wrst_cnt_q <= wrst_cnt_q - CntW'(1);
            end
          end
          StWaitFall: begin
            if (vs_fall) begin
              wen        <= 1'b1;
              line_cnt_q <= 9'd0;
              state_q    <= StCapture;
            end
          end
          StCapture: begin
            line_cnt_q <= line_cnt_inc;
            if (vs_rise) begin
              wen <= 1'b0;
              if (line_cnt_inc == ExpLines) begin
                new_frame   <= 1'b1;
                frame_count <= frame_count + 8'd1;
                state_q     <= StHandoff;
              end else begin
                // Short/long frame: this vsync doubles as the start of the retry frame.
                frame_err   <= 1'b1;
                wrst        <= 1'b0;
                wrst_cnt_q  <= WrstLoad;
                fall_pend_q <= 1'b0;
                state_q     <= StWrst;
              end
            end
          end
          StHandoff: begin
            if (!frame_read) begin
              new_frame <= 1'b0;
              state_q   <= StBusy;
            end
          end
          StBusy: begin
            if (frame_read) begin
              state_q <= StWaitStart;
            end
          end
          default: begin
            state_q   <= StIdle;
            wen       <= 1'b0;
            wrst      <= 1'b1;
            new_frame <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ov_fifo_write.md
OV_FIFO_WRITE -- requirements
Module: ov_fifo_write

Interface
REQ-001 SHALL have parameter EXPECT_LINES, default 240, the number of HREF lines that make a valid frame.
REQ-002 SHALL have parameter WRST_CYCLES, default 4, the number of clk_25MHz cycles WRST is held low.
REQ-003 SHALL have port clk_25MHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port initialized  input  1  high once the camera register setup is complete.
REQ-006 SHALL have port vsync  input  1  camera VSYNC, asynchronous to clk_25MHz; a high pulse marks the frame boundary.
REQ-007 SHALL have port href  input  1  camera HREF, asynchronous; one high pulse per line.
REQ-008 SHALL have port frame_read  input  1  reader status: low while the reader drains the FIFO, high when idle.
REQ-009 SHALL have port wen  output  1  AL422 write enable, active-high.
REQ-010 SHALL have port wrst  output  1  AL422 write-pointer reset, active-low.
REQ-011 SHALL have port new_frame  output  1  level: a complete frame is in the FIFO and is not yet claimed.
REQ-012 SHALL have port frame_count  output  8  number of frames handed off.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse when a captured frame has the wrong line count.

Function
REQ-014 SHALL pass vsync and href each through a 2-flop synchronizer plus a third flop for edge detection.
REQ-015 Rise = stage2 & ~stage3 and fall = ~stage2 & stage3; an FSM reaction SHALL be registered on the 3rd rising edge counting the edge that first samples the pin change.
REQ-016 SHALL implement FSM states IDLE, WAIT_START, WRST, WAIT_FALL, CAPTURE, HANDOFF, BUSY.
REQ-017 IDLE -> WAIT_START when initialized=1, frame_read=1 and new_frame=0.
REQ-018 WAIT_START: on vsync rise, set wrst<=0, load the cycle counter with WRST_CYCLES, -> WRST.
REQ-019 WRST: hold wrst=0 for exactly WRST_CYCLES cycles, then wrst<=1 and -> WAIT_FALL.
REQ-020 WAIT_FALL: on vsync fall, set wen<=1 and line_cnt<=0, -> CAPTURE; a vsync fall that arrives while in WRST SHALL be latched and acted on at WRST exit.
REQ-021 CAPTURE: each href rise SHALL increment the 9-bit line_cnt, saturating at 511.
REQ-022 CAPTURE, on vsync rise: set wen<=0; if line_cnt==EXPECT_LINES, set new_frame<=1, increment frame_count and -> HANDOFF.
REQ-023 CAPTURE, on vsync rise with line_cnt!=EXPECT_LINES: pulse frame_err for 1 cycle, set wrst<=0, reload the counter and -> WRST; this vsync starts the retry frame.
REQ-024 An href rise and a vsync rise in the same cycle SHALL count the line before the compare.
REQ-025 HANDOFF: when frame_read=0, set new_frame<=0 and -> BUSY; wen SHALL stay 0.
REQ-026 BUSY: when frame_read=1, -> WAIT_START; the next frame is captured only after the reader finishes.
REQ-027 frame_count SHALL wrap from 255 to 0.
REQ-028 If initialized=0 in any state other than IDLE, the FSM SHALL return to IDLE the next cycle with wen=0, wrst=1 and new_frame=0; frame_count is retained.
REQ-029 wen SHALL never be 1 while wrst=0.
REQ-030 An unreachable state encoding SHALL return the FSM to IDLE.

Reset
REQ-031 With rst_n=0, the block SHALL asynchronously force wen=0, wrst=1, new_frame=0, frame_count=0, frame_err=0, line_cnt=0, state=IDLE and all synchronizer flops to 0.
REQ-032 Reset deassertion SHALL take effect at the next clk_25MHz edge, with no spurious edge detected from the cleared synchronizers.
REQ-033 Reset mid-CAPTURE SHALL drop wen immediately, asynchronously.

Verification
REQ-034 Nominal: initialized=1, frame_read=1, vsync pulse, 240 href pulses, vsync pulse -> wrst low for 4 cycles starting 3 edges after the first vsync rise; wen high from vsync fall+3 to the second vsync rise+3; new_frame=1; frame_count=1.
REQ-035 Handoff: after REQ-034, drive frame_read 0 then back to 1 -> new_frame drops 1 cycle after frame_read=0; a third vsync rise during BUSY is ignored; the next vsync after frame_read=1 starts WRST.
REQ-036 Bad frame: 239 href pulses between vsyncs -> frame_err pulses 1 cycle, new_frame stays 0, wrst goes low at the same edge, and capture restarts; 240 lines next -> new_frame=1.
REQ-037 Abort: deassert initialized mid-CAPTURE -> next cycle wen=0, wrst=1, state IDLE; re-assert -> a fresh WRST on the next vsync rise.
REQ-038 Wrap: 256 complete handoffs -> frame_count returns to 0x00; 0xFF is seen before it.
REQ-039 Reset: assert rst_n=0 mid-CAPTURE -> wen=0 with no clock edge; after release, outputs equal their REQ-031 values until a vsync rise.
